// File: rtl/fencing_action_fsm.sv
// Per-player saber action controller: steps once per video frame and emits a registered player record.
// Optional block fatigue limit is enabled with `define FENCE_BLOCK_FATIGUE_EN.
module fencing_action_fsm #(
   parameter int X_W              = 11,
   parameter int Y_W              = 10,
   parameter int HEALTH_W         = 3,
   parameter int HEALTH_INIT      = 5,
   parameter int ATTACK_FRAMES    = 8,
   parameter int RECOVER_FRAMES   = 4,
   parameter int BLOCK_MAX_FRAMES = 30
) (
   input  logic                clk_pixel_in,
   input  logic                rst_n_in,
   input  logic                ir_in_valid,
   input  logic                block_in,
   input  logic                lunge_in,
   input  logic                release_in,
   input  logic                frame_valid_in,
   input  logic [X_W-1:0]      saber_x_in,
   input  logic [Y_W-1:0]      saber_y_in,
   input  logic                attack_hit_in,
   input  logic                sabers_colliding_in,
   input  logic                opponent_scored_in,
   output logic [1:0]          saber_state_out,
   output logic [X_W-1:0]      attack_x_out,
   output logic [Y_W-1:0]      attack_y_out,
   output logic [HEALTH_W-1:0] health_out,
   output logic                player_scored_out,
   output logic                game_over_out,
   output logic                out_valid
);

   localparam int AT_W = $clog2(ATTACK_FRAMES + 1);
   localparam int RT_W = $clog2(RECOVER_FRAMES + 1);

   typedef enum logic [2:0] {
      S_REST    = 3'd0,
      S_ATTACK  = 3'd1,
      S_BLOCK   = 3'd2,
      S_SCORE   = 3'd3,
      S_RECOVER = 3'd4,
      S_DEAD    = 3'd5
   } state_e;

   state_e              state_q;
   logic                blk_q, lng_q, rel_q;
   logic [AT_W-1:0]     atk_tmr_q;
   logic [RT_W-1:0]     rec_tmr_q;
   logic [X_W-1:0]      ax_q;
   logic [Y_W-1:0]      ay_q;
   logic [HEALTH_W-1:0] health_q, health_d;
   logic                scored_q, over_q, vld_q;
   logic                die;
   logic                blk_go;

   assign health_d = (opponent_scored_in && health_q != '0) ? health_q - 1'b1 : health_q;
   assign die      = (health_d == '0);

`ifdef FENCE_BLOCK_FATIGUE_EN
   localparam int BC_W = $clog2(BLOCK_MAX_FRAMES + 1);
   logic [BC_W-1:0] bcnt_q;
   logic            arm_q;
   // After a fatigue timeout the block button must be seen released before BLOCK is re-entered.
   assign blk_go = blk_q && arm_q;
`else
   logic unused_bmf;
   assign unused_bmf = |32'(BLOCK_MAX_FRAMES);
   assign blk_go     = blk_q;
`endif

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_REST;
         blk_q     <= 1'b0;
         lng_q     <= 1'b0;
         rel_q     <= 1'b0;
         atk_tmr_q <= '0;
         rec_tmr_q <= '0;
         ax_q      <= '0;
         ay_q      <= '0;
         health_q  <= HEALTH_W'(HEALTH_INIT);
         scored_q  <= 1'b0;
         over_q    <= 1'b0;
         vld_q     <= 1'b0;
`ifdef FENCE_BLOCK_FATIGUE_EN
         bcnt_q    <= '0;
         arm_q     <= 1'b1;
`endif
      end else begin
         vld_q <= frame_valid_in;
         if (ir_in_valid) begin
            blk_q <= block_in;
            lng_q <= lunge_in;
            rel_q <= release_in;
         end
`ifdef FENCE_BLOCK_FATIGUE_EN
         if (!blk_q) arm_q <= 1'b1;
`endif
         if (frame_valid_in) begin
            scored_q <= 1'b0;
            health_q <= health_d;
            case (state_q)
               S_REST: begin
                  if (blk_go) begin
                     state_q <= S_BLOCK;
`ifdef FENCE_BLOCK_FATIGUE_EN
                     bcnt_q  <= '0;
`endif
                  end else if (lng_q) begin
                     state_q   <= S_ATTACK;
                     ax_q      <= saber_x_in;
                     ay_q      <= saber_y_in;
                     atk_tmr_q <= '0;
                  end
               end
               S_BLOCK: begin
                  if (!blk_q) begin
                     state_q <= S_REST;
`ifdef FENCE_BLOCK_FATIGUE_EN
                  end else if (bcnt_q == BC_W'(BLOCK_MAX_FRAMES - 1)) begin
                     state_q   <= S_RECOVER;
                     rec_tmr_q <= '0;
                     arm_q     <= 1'b0;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
`endif
                  end
               end
               S_ATTACK: begin
                  if (rel_q && attack_hit_in) begin
                     state_q  <= S_SCORE;
                     scored_q <= 1'b1;
                  end else if (sabers_colliding_in) begin
                     state_q   <= S_RECOVER;
                     rec_tmr_q <= '0;
                     ax_q      <= '0;
                     ay_q      <= '0;
                     // A same-cycle button update wins over the parry clear.
                     if (!ir_in_valid) lng_q <= 1'b0;
                  end else if (rel_q || atk_tmr_q == AT_W'(ATTACK_FRAMES - 1)) begin
                     state_q   <= S_RECOVER;
                     rec_tmr_q <= '0;
                     ax_q      <= '0;
                     ay_q      <= '0;
                  end else begin
                     atk_tmr_q <= atk_tmr_q + 1'b1;
                  end
               end
               S_SCORE: begin
                  state_q   <= S_RECOVER;
                  rec_tmr_q <= '0;
                  ax_q      <= '0;
                  ay_q      <= '0;
               end
               S_RECOVER: begin
                  if (rec_tmr_q == RT_W'(RECOVER_FRAMES - 1)) state_q <= S_REST;
                  else rec_tmr_q <= rec_tmr_q + 1'b1;
               end
               S_DEAD: state_q <= S_DEAD;
               default: begin
                  state_q <= S_REST;
                  ax_q    <= '0;
                  ay_q    <= '0;
               end
            endcase
            // Losing the last health point overrides any transition, but a score pulse stands.
            if (die) begin
               state_q <= S_DEAD;
               ax_q    <= '0;
               ay_q    <= '0;
               over_q  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      saber_state_out = 2'b00;
      case (state_q)
         S_REST:    saber_state_out = 2'b00;
         S_ATTACK:  saber_state_out = 2'b01;
         S_BLOCK:   saber_state_out = 2'b10;
         S_SCORE,
         S_RECOVER,
         S_DEAD:    saber_state_out = 2'b11;
         default:   saber_state_out = 2'b00;
      endcase
   end

   assign attack_x_out      = ax_q;
   assign attack_y_out      = ay_q;
   assign health_out        = health_q;
   assign player_scored_out = scored_q;
   assign game_over_out     = over_q;
   assign out_valid         = vld_q;

endmodule
